// File: rtl/detection_unit.sv
// Hazard detection and operand-forwarding select for the 3-wide in-order pipeline.
// Optional macro DETECTION_REG_OUT_EN registers every output (1-cycle latency).
`ifndef ZERO_REG
`define ZERO_REG 5'd0
`endif
`ifndef NOP
`define NOP 32'h00000013
`endif

package sys_defs;
  typedef enum logic [2:0] {
    RS_REG, RS_EX_0, RS_EX_1, RS_EX_2, RS_MEM_0, RS_MEM_1, RS_MEM_2
  } RS_SELECT;

  typedef struct packed {
    logic [6:0] funct7;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] funct3;
    logic [4:0] rd;
    logic [6:0] opcode;
  } R_FMT;

  typedef union packed {
    logic [31:0] bits;
    R_FMT        r;
  } INST;

  typedef struct packed {
    INST         inst;
    logic [31:0] PC;
    logic [4:0]  dest_reg_idx;
    logic        rd_mem, wr_mem, cond_branch, uncond_branch, halt, valid;
  } ID_EX_PACKET;

  typedef struct packed {
    logic [31:0] alu_result;
    logic [4:0]  dest_reg_idx;
    logic        rd_mem, wr_mem, halt, valid;
  } EX_MEM_PACKET;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
endpackage

// One lane: hazard flag and unsquashed forwarding selects for its two sources.
module detection_lane
  import sys_defs::*;
(
  input  logic [6:0]      opcode,
  input  logic [4:0]      rs1,
  input  logic [4:0]      rs2,
  input  logic [2:0][4:0] older_dest,
  input  logic [2:0][4:0] ex_dest,
  input  logic [2:0]      ex_rd_mem,
  input  logic [2:0][4:0] mem_dest,
  output logic            hazard,
  output RS_SELECT        fwd_a,
  output RS_SELECT        fwd_b
);
  function automatic logic [2:0] hits(input logic [2:0][4:0] dest, input logic [4:0] src);
    hits = '0;
    for (int k = 0; k < 3; k++) hits[k] = (src != `ZERO_REG) && (dest[k] == src);
  endfunction

  // Only the youngest EX writer matters: a later ALU op shadows an older load.
  function automatic logic loaded(input logic [2:0] m, input logic [2:0] ld);
    if (m[2])      loaded = ld[2];
    else if (m[1]) loaded = ld[1];
    else           loaded = m[0] & ld[0];
  endfunction

  function automatic RS_SELECT pick(input logic [2:0] ex_m, input logic [2:0] mem_m);
    if (ex_m[2])       pick = RS_EX_2;
    else if (ex_m[1])  pick = RS_EX_1;
    else if (ex_m[0])  pick = RS_EX_0;
    else if (mem_m[2]) pick = RS_MEM_2;
    else if (mem_m[1]) pick = RS_MEM_1;
    else if (mem_m[0]) pick = RS_MEM_0;
    else               pick = RS_REG;
  endfunction

  logic       use1, use2;
  logic [2:0] id1, id2, ex1, ex2, mem1, mem2;

  assign use1 = !(opcode inside {OP_LUI, OP_AUIPC, OP_JAL}) && (rs1 != `ZERO_REG);
  assign use2 = (opcode inside {OP_R, OP_STORE, OP_BRANCH}) && (rs2 != `ZERO_REG);

  assign id1  = hits(older_dest, rs1);
  assign id2  = hits(older_dest, rs2);
  assign ex1  = hits(ex_dest, rs1);
  assign ex2  = hits(ex_dest, rs2);
  assign mem1 = hits(mem_dest, rs1);
  assign mem2 = hits(mem_dest, rs2);

  assign hazard = (use1 && ((|id1) || loaded(ex1, ex_rd_mem)))
               || (use2 && ((|id2) || loaded(ex2, ex_rd_mem)));
  assign fwd_a  = use1 ? pick(ex1, mem1) : RS_REG;
  assign fwd_b  = use2 ? pick(ex2, mem2) : RS_REG;
endmodule

module detection_unit
  import sys_defs::*;
(
  input  logic           clock,
  input  logic           reset,
  input  ID_EX_PACKET    id_packet_0,
  input  ID_EX_PACKET    id_packet_1,
  input  ID_EX_PACKET    id_packet_2,
  input  ID_EX_PACKET    ex_packet_0,
  input  ID_EX_PACKET    ex_packet_1,
  input  ID_EX_PACKET    ex_packet_2,
  input  EX_MEM_PACKET   mem_packet_0,
  input  EX_MEM_PACKET   mem_packet_1,
  input  EX_MEM_PACKET   mem_packet_2,
  output ID_EX_PACKET    id_packet_out_0,
  output ID_EX_PACKET    id_packet_out_1,
  output ID_EX_PACKET    id_packet_out_2,
  output logic [1:0]     rollback,
  output RS_SELECT [3:0] forwarding_A,
  output RS_SELECT [3:0] forwarding_B
);
  function automatic ID_EX_PACKET bubble(input ID_EX_PACKET p);
    bubble               = p;
    bubble.inst.bits     = `NOP;
    bubble.dest_reg_idx  = `ZERO_REG;
    bubble.valid         = 1'b0;
    bubble.rd_mem        = 1'b0;
    bubble.wr_mem        = 1'b0;
    bubble.cond_branch   = 1'b0;
    bubble.uncond_branch = 1'b0;
    bubble.halt          = 1'b0;
  endfunction

  ID_EX_PACKET [2:0]     id;
  logic [2:0][4:0]       ex_dest, mem_dest;
  logic [2:0]            ex_rd_mem, hazard, kill;
  RS_SELECT [2:0]        lane_fa, lane_fb;
  logic [1:0]            nxt_rollback;
  RS_SELECT [3:0]        nxt_fa, nxt_fb;
  ID_EX_PACKET [2:0]     nxt_pkt;
  logic                  unused_bits;

  assign id        = {id_packet_2, id_packet_1, id_packet_0};
  assign ex_dest   = {ex_packet_2.dest_reg_idx, ex_packet_1.dest_reg_idx, ex_packet_0.dest_reg_idx};
  assign ex_rd_mem = {ex_packet_2.rd_mem, ex_packet_1.rd_mem, ex_packet_0.rd_mem};
  assign mem_dest  = {mem_packet_2.dest_reg_idx, mem_packet_1.dest_reg_idx, mem_packet_0.dest_reg_idx};
  assign unused_bits = ^{ex_packet_0, ex_packet_1, ex_packet_2, mem_packet_0, mem_packet_1, mem_packet_2};

  genvar l, i;
  for (l = 0; l < 3; l++) begin : g_lane
    logic [2:0][4:0] older;
    for (i = 0; i < 3; i++) begin : g_older
      assign older[i] = (i < l) ? id[i].dest_reg_idx : `ZERO_REG;
    end
    detection_lane u_lane (
      .opcode    (id[l].inst.r.opcode),
      .rs1       (id[l].inst.r.rs1),
      .rs2       (id[l].inst.r.rs2),
      .older_dest(older),
      .ex_dest   (ex_dest),
      .ex_rd_mem (ex_rd_mem),
      .mem_dest  (mem_dest),
      .hazard    (hazard[l]),
      .fwd_a     (lane_fa[l]),
      .fwd_b     (lane_fb[l])
    );
  end

  // Everything from the oldest hazardous lane onward is squashed; reset squashes all.
  always_comb begin
    kill[0] = hazard[0];
    kill[1] = kill[0] | hazard[1];
    kill[2] = kill[1] | hazard[2];
    nxt_rollback = kill[0] ? 2'd3 : kill[1] ? 2'd2 : kill[2] ? 2'd1 : 2'd0;
    if (reset) begin
      kill         = 3'b111;
      nxt_rollback = 2'd0;
    end
    for (int k = 0; k < 3; k++) begin
      nxt_pkt[k] = kill[k] ? bubble(id[k]) : id[k];
      nxt_fa[k]  = kill[k] ? RS_REG : lane_fa[k];
      nxt_fb[k]  = kill[k] ? RS_REG : lane_fb[k];
    end
    nxt_fa[3] = RS_REG;
    nxt_fb[3] = RS_REG;
  end

`ifdef DETECTION_REG_OUT_EN
  logic [1:0]        q_rollback;
  RS_SELECT [3:0]    q_fa, q_fb;
  ID_EX_PACKET [2:0] q_pkt;

  always_ff @(posedge clock) begin
    if (reset) begin
      q_rollback <= 2'd0;
      for (int k = 0; k < 4; k++) begin
        q_fa[k] <= RS_REG;
        q_fb[k] <= RS_REG;
      end
      for (int k = 0; k < 3; k++) q_pkt[k] <= bubble(id[k]);
    end else begin
      q_rollback <= nxt_rollback;
      q_fa       <= nxt_fa;
      q_fb       <= nxt_fb;
      q_pkt      <= nxt_pkt;
    end
  end

  assign rollback        = q_rollback;
  assign forwarding_A    = q_fa;
  assign forwarding_B    = q_fb;
  assign id_packet_out_0 = q_pkt[0];
  assign id_packet_out_1 = q_pkt[1];
  assign id_packet_out_2 = q_pkt[2];
`else
  logic unused_clock;
  assign unused_clock    = clock;
  assign rollback        = nxt_rollback;
  assign forwarding_A    = nxt_fa;
  assign forwarding_B    = nxt_fb;
  assign id_packet_out_0 = nxt_pkt[0];
  assign id_packet_out_1 = nxt_pkt[1];
  assign id_packet_out_2 = nxt_pkt[2];
`endif
endmodule

// File: tb/tb_detection_unit.sv
// Directed bench for detection_unit (combinational build): per-cycle model compare plus literal pins.
module tb_detection_unit;
  import sys_defs::*;

  logic           clock = 1'b0;
  logic           reset = 1'b1;
  ID_EX_PACKET    id  [3];
  ID_EX_PACKET    ex  [3];
  EX_MEM_PACKET   mem [3];
  ID_EX_PACKET    po  [3];
  logic [1:0]     rollback;
  RS_SELECT [3:0] forwarding_A, forwarding_B;

  int nvec = 0;
  int nerr = 0;
  bit started = 1'b0;

  logic [1:0]  m_rb;
  RS_SELECT    m_fa [4];
  RS_SELECT    m_fb [4];
  ID_EX_PACKET m_po [3];

  detection_unit dut (
    .clock(clock), .reset(reset),
    .id_packet_0(id[0]), .id_packet_1(id[1]), .id_packet_2(id[2]),
    .ex_packet_0(ex[0]), .ex_packet_1(ex[1]), .ex_packet_2(ex[2]),
    .mem_packet_0(mem[0]), .mem_packet_1(mem[1]), .mem_packet_2(mem[2]),
    .id_packet_out_0(po[0]), .id_packet_out_1(po[1]), .id_packet_out_2(po[2]),
    .rollback(rollback), .forwarding_A(forwarding_A), .forwarding_B(forwarding_B)
  );

  always #5 clock = ~clock;

  // Instruction encoders
  function automatic logic [31:0] i_addi(input logic [4:0] rd, rs1, input logic [11:0] imm);
    return {imm, rs1, 3'b000, rd, 7'b0010011};
  endfunction
  function automatic logic [31:0] i_add(input logic [4:0] rd, rs1, rs2);
    return {7'h0, rs2, rs1, 3'b000, rd, 7'b0110011};
  endfunction
  function automatic logic [31:0] i_lw(input logic [4:0] rd, rs1);
    return {12'h0, rs1, 3'b010, rd, 7'b0000011};
  endfunction
  function automatic logic [31:0] i_sw(input logic [4:0] rs2, rs1);
    return {7'h0, rs2, rs1, 3'b010, 5'h0, 7'b0100011};
  endfunction
  function automatic logic [31:0] i_beq(input logic [4:0] rs1, rs2);
    return {7'h0, rs2, rs1, 3'b000, 5'h0, 7'b1100011};
  endfunction
  function automatic logic [31:0] i_up(input logic [6:0] op, input logic [4:0] rd, field);
    return {12'h0ab, field, 3'b000, rd, op};
  endfunction

  function automatic ID_EX_PACKET pk(input logic [31:0] bits);
    ID_EX_PACKET p;
    p = '0;
    p.inst.bits = bits;
    p.PC = 32'h0000_1000;
    p.valid = 1'b1;
    p.dest_reg_idx = (bits[6:0] == 7'b0100011 || bits[6:0] == 7'b1100011) ? 5'd0 : bits[11:7];
    p.rd_mem = (bits[6:0] == 7'b0000011);
    p.wr_mem = (bits[6:0] == 7'b0100011);
    p.cond_branch = (bits[6:0] == 7'b1100011);
    p.uncond_branch = (bits[6:0] == 7'b1101111);
    return p;
  endfunction

  function automatic EX_MEM_PACKET mp(input logic [4:0] rd);
    EX_MEM_PACKET p;
    p = '0;
    p.alu_result = 32'hdead_beef;
    p.dest_reg_idx = rd;
    p.valid = 1'b1;
    return p;
  endfunction

  function automatic ID_EX_PACKET tb_bub(input ID_EX_PACKET p);
    ID_EX_PACKET b;
    b = p;
    b.inst.bits = 32'h0000_0013;
    b.dest_reg_idx = 5'd0;
    b.valid = 1'b0; b.rd_mem = 1'b0; b.wr_mem = 1'b0;
    b.cond_branch = 1'b0; b.uncond_branch = 1'b0; b.halt = 1'b0;
    return b;
  endfunction

  // Model: per-register producer tables, then scan lanes for the oldest bad one.
  function automatic void run_model();
    int ex_own [32];
    int mem_own [32];
    logic [4:0] src [3][2];
    bit used [3][2];
    int first;
    logic [6:0] op;
    bit bad, sq;
    for (int r = 0; r < 32; r++) begin ex_own[r] = -1; mem_own[r] = -1; end
    for (int k = 0; k < 3; k++) begin
      if (ex[k].dest_reg_idx != 5'd0)  ex_own[ex[k].dest_reg_idx] = k;
      if (mem[k].dest_reg_idx != 5'd0) mem_own[mem[k].dest_reg_idx] = k;
    end
    for (int j = 0; j < 3; j++) begin
      op = id[j].inst.bits[6:0];
      src[j][0] = id[j].inst.bits[19:15];
      src[j][1] = id[j].inst.bits[24:20];
      used[j][0] = (op != 7'b0110111) && (op != 7'b0010111) && (op != 7'b1101111) && (src[j][0] != 0);
      used[j][1] = (op == 7'b0110011 || op == 7'b0100011 || op == 7'b1100011) && (src[j][1] != 0);
    end
    first = 3;
    for (int j = 2; j >= 0; j--) begin
      bad = 1'b0;
      for (int n = 0; n < 2; n++) if (used[j][n]) begin
        for (int i = 0; i < j; i++) if (id[i].dest_reg_idx == src[j][n]) bad = 1'b1;
        if (ex_own[src[j][n]] >= 0 && ex[ex_own[src[j][n]]].rd_mem) bad = 1'b1;
      end
      if (bad) first = j;
    end
    m_rb = reset ? 2'd0 : 2'(3 - first);
    for (int j = 0; j < 3; j++) begin
      sq = reset || (j >= first);
      m_po[j] = sq ? tb_bub(id[j]) : id[j];
      for (int n = 0; n < 2; n++) begin
        RS_SELECT s;
        s = RS_REG;
        if (!sq && used[j][n]) begin
          if (ex_own[src[j][n]] >= 0)       s = RS_SELECT'(1 + ex_own[src[j][n]]);
          else if (mem_own[src[j][n]] >= 0) s = RS_SELECT'(4 + mem_own[src[j][n]]);
        end
        if (n == 0) m_fa[j] = s; else m_fb[j] = s;
      end
    end
    m_fa[3] = RS_REG;
    m_fb[3] = RS_REG;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic pin(input string name, input logic [127:0] act, input logic [127:0] mdl,
                     input logic [127:0] lit);
    nvec++;
    if (act !== lit || mdl !== lit) begin
      nerr++;
      $display("FAIL %s: dut %0h model %0h required %0h", name, act, mdl, lit);
    end
  endtask

  always @(negedge clock) if (started) begin
    run_model();
    chk("rollback", rollback, m_rb);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("fwdA[%0d]", k), forwarding_A[k], m_fa[k]);
      chk($sformatf("fwdB[%0d]", k), forwarding_B[k], m_fb[k]);
    end
    for (int k = 0; k < 3; k++) chk($sformatf("pkt_out[%0d]", k), po[k], m_po[k]);
  end

  task automatic clear_pipe();
    for (int k = 0; k < 3; k++) begin ex[k] = '0; mem[k] = '0; end
  endtask
  task automatic base();
    id[0] = pk(i_addi(5'd1, 5'd1, 12'd1));
    id[1] = pk(i_addi(5'd2, 5'd2, 12'd2));
    id[2] = pk(i_addi(5'd3, 5'd3, 12'd3));
  endtask
  task automatic settle(); @(negedge clock); run_model(); endtask
  task automatic next();   @(posedge clock); #1; clear_pipe(); endtask

  initial begin
    clear_pipe();
    id[0] = pk(i_addi(5'd1, 5'd1, 12'd1));
    id[1] = pk(i_addi(5'd2, 5'd1, 12'd1));
    id[2] = pk(i_addi(5'd3, 5'd3, 12'd3));
    reset = 1'b1;
    started = 1'b1;
    settle();
    pin("rst_rollback", rollback, m_rb, 2'd0);
    pin("rst_fwdA1", forwarding_A[1], m_fa[1], RS_REG);
    pin("rst_inst0", po[0].inst.bits, m_po[0].inst.bits, 32'h13);
    pin("rst_valid2", po[2].valid, m_po[2].valid, 1'b0);

    next(); reset = 1'b0; base(); settle();
    pin("indep_rb", rollback, m_rb, 2'd0);
    pin("indep_pass1", po[1], m_po[1], id[1]);
    pin("indep_fwdA0", forwarding_A[0], m_fa[0], RS_REG);

    next(); id[0] = pk(i_addi(5'd1, 5'd1, 12'd1)); id[1] = pk(i_addi(5'd2, 5'd1, 12'd1));
    id[2] = pk(i_addi(5'd3, 5'd3, 12'd3)); settle();
    pin("intra1_rb", rollback, m_rb, 2'd2);
    pin("intra1_inst1", po[1].inst.bits, m_po[1].inst.bits, 32'h13);
    pin("intra1_pass0", po[0], m_po[0], id[0]);

    next(); base(); id[2] = pk(i_addi(5'd2, 5'd1, 12'd1)); settle();
    pin("intra2_rb", rollback, m_rb, 2'd1);

    next(); base(); id[1] = pk(i_add(5'd3, 5'd4, 5'd1)); settle();
    pin("intra_rs2_rb", rollback, m_rb, 2'd2);

    next(); base(); ex[0] = pk(i_lw(5'd1, 5'd1)); settle();
    pin("lu_ex0_rb", rollback, m_rb, 2'd3);
    pin("lu_ex0_valid0", po[0].valid, m_po[0].valid, 1'b0);

    next(); base(); ex[1] = pk(i_lw(5'd2, 5'd2)); settle();
    pin("lu_ex1_rb", rollback, m_rb, 2'd2);

    next(); base(); ex[2] = pk(i_lw(5'd3, 5'd3)); ex[0] = pk(i_addi(5'd2, 5'd2, 12'd7)); settle();
    pin("lu_ex2_rb", rollback, m_rb, 2'd1);
    pin("lu_ex2_fwdA1", forwarding_A[1], m_fa[1], RS_EX_0);
    pin("lu_ex2_fwdA2", forwarding_A[2], m_fa[2], RS_REG);

    next(); base(); ex[1] = pk(i_lw(5'd1, 5'd1)); ex[2] = pk(i_addi(5'd1, 5'd1, 12'd1)); settle();
    pin("shadow_rb", rollback, m_rb, 2'd0);
    pin("shadow_fwdA0", forwarding_A[0], m_fa[0], RS_EX_2);

    next();
    id[0] = pk(i_add(5'd3, 5'd1, 5'd2)); id[1] = pk(i_addi(5'd2, 5'd2, 12'd2));
    id[2] = pk(i_addi(5'd1, 5'd1, 12'd1));
    ex[0] = pk(i_addi(5'd1, 5'd1, 12'd0)); ex[1] = pk(i_addi(5'd2, 5'd2, 12'd0)); settle();
    pin("fwd_ex_rb", rollback, m_rb, 2'd0);
    pin("fwd_ex_A0", forwarding_A[0], m_fa[0], RS_EX_0);
    pin("fwd_ex_A1", forwarding_A[1], m_fa[1], RS_EX_1);
    pin("fwd_ex_A2", forwarding_A[2], m_fa[2], RS_EX_0);
    pin("fwd_ex_B0", forwarding_B[0], m_fb[0], RS_EX_1);
    pin("fwd_ex_B1", forwarding_B[1], m_fb[1], RS_REG);
    pin("fwd_ex_A3", forwarding_A[3], m_fa[3], RS_REG);

    next();
    id[0] = pk(i_add(5'd3, 5'd1, 5'd2)); id[1] = pk(i_addi(5'd2, 5'd2, 12'd2));
    id[2] = pk(i_addi(5'd1, 5'd1, 12'd1));
    ex[1] = pk(i_addi(5'd2, 5'd2, 12'd0)); mem[0] = mp(5'd1); settle();
    pin("fwd_mem_A0", forwarding_A[0], m_fa[0], RS_MEM_0);
    pin("fwd_mem_B0", forwarding_B[0], m_fb[0], RS_EX_1);
    pin("fwd_mem_A2", forwarding_A[2], m_fa[2], RS_MEM_0);

    next();
    id[0] = pk(i_up(7'b0110111, 5'd5, 5'd1)); id[1] = pk(i_sw(5'd9, 5'd0));
    id[2] = pk(i_beq(5'd5, 5'd8));
    ex[0] = pk(i_lw(5'd1, 5'd1)); mem[0] = mp(5'd9); mem[2] = mp(5'd9); settle();
    pin("mix_rb", rollback, m_rb, 2'd1);
    pin("mix_fwdA0", forwarding_A[0], m_fa[0], RS_REG);
    pin("mix_fwdB1", forwarding_B[1], m_fb[1], RS_MEM_2);
    pin("mix_fwdA1", forwarding_A[1], m_fa[1], RS_REG);
    pin("mix_branch2", po[2].cond_branch, m_po[2].cond_branch, 1'b0);

    next();
    id[0] = pk(i_addi(5'd0, 5'd1, 12'd1)); id[1] = pk(i_add(5'd4, 5'd0, 5'd0));
    id[2] = pk(i_up(7'b1101111, 5'd1, 5'd4));
    ex[0] = pk(i_lw(5'd0, 5'd0)); settle();
    pin("x0_rb", rollback, m_rb, 2'd0);
    pin("x0_fwdA2", forwarding_A[2], m_fa[2], RS_REG);
    pin("x0_pass2", po[2], m_po[2], id[2]);

    next(); reset = 1'b1; base(); ex[0] = pk(i_lw(5'd1, 5'd1)); settle();
    pin("rst2_rb", rollback, m_rb, 2'd0);
    pin("rst2_dest1", po[1].dest_reg_idx, m_po[1].dest_reg_idx, 5'd0);

    next(); reset = 1'b0; base(); settle();
    started = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/detection_unit.md
# detection_unit

Hazard-detection and forwarding-select block for the 3-wide in-order superscalar pipeline. It sits between ID and EX, sees the three decoded ID packets plus the three EX and three MEM packets in flight, and does four things: detects intra-bundle RAW hazards, detects load-use hazards, emits a rollback count, and emits per-lane operand forwarding selects. Lane 0 is the oldest instruction in every stage and lane 2 the youngest.

## Interface
- No parameters; width 3 lanes fixed.
- clock  in  1  pipeline clock.
- reset  in  1  synchronous, active-high reset.
- id_packet_0..2  in  ID_EX_PACKET  decoded bundle, lanes 0..2.
- ex_packet_0..2  in  ID_EX_PACKET  bundle currently in EX.
- mem_packet_0..2  in  EX_MEM_PACKET  bundle currently in MEM.
- id_packet_out_0..2  out  ID_EX_PACKET  bundle forwarded to ID/EX; squashed lanes are bubbles.
- rollback  out  2  number of youngest lanes squashed (0 none, 1 lane 2, 2 lanes 1-2, 3 all).
- forwarding_A  out  RS_SELECT[3:0]  rs1 source per lane; element 3 always RS_REG.
- forwarding_B  out  RS_SELECT[3:0]  rs2 source per lane; element 3 always RS_REG.
- RS_SELECT (sys_defs) members: RS_REG, RS_EX_0, RS_EX_1, RS_EX_2, RS_MEM_0, RS_MEM_1, RS_MEM_2.

## Operation
- Sources: rs1 = inst.r.rs1, rs2 = inst.r.rs2.
- rs1 is used unless the opcode is LUI, AUIPC or JAL.
- rs2 is used only for R-type, STORE and BRANCH opcodes.
- A source equal to x0 never hazards and never forwards.
- Writer: a packet writes when dest_reg_idx != `ZERO_REG`. WAW is never a hazard.
- Intra-bundle hazard: lane j is hazardous if any used source of lane j equals dest_reg_idx of an older ID lane i < j.
- Load-use hazard: lane j is hazardous if the youngest EX lane writing a used source of lane j has rd_mem = 1.
  - Example: EX lane 1 = lw x1 and EX lane 2 = addi x1 is not a hazard.
- rollback = 3 - j, where j is the oldest hazardous lane; rollback = 0 if no lane is hazardous.
- Forwarding select, per used source of each lane that is not squashed:
  - RS_EX_k, where k is the youngest EX lane writing that register;
  - else RS_MEM_k, where k is the youngest MEM lane writing it;
  - else RS_REG.
  - Unused sources and squashed lanes output RS_REG.
- id_packet_out_i: pass-through of id_packet_i when lane i is not squashed.
- Squashed-lane bubble: inst = `NOP`, dest_reg_idx = `ZERO_REG`; valid, rd_mem, wr_mem, cond_branch, uncond_branch and halt are cleared; all other fields pass through.

## Timing
- Default build is purely combinational: outputs follow inputs in the same cycle, with zero latency.
- When reset is sampled high, outputs are forced to the neutral state, gated combinationally during the reset cycle(s):
  - rollback = 0;
  - all forwarding selects = RS_REG;
  - all three id_packet_out are bubbles.
- With registered outputs enabled (see Configuration), all outputs are captured on the posedge clock, giving 1-cycle latency. A synchronous reset loads the neutral state; reset asserted mid-operation discards the pending result.
- Simultaneous intra-bundle and load-use hazards: the oldest hazardous lane wins.

## Configuration
- DETECTION_REG_OUT_EN defined: all outputs are registered (1-cycle latency, synchronous reset to the neutral state).
- DETECTION_REG_OUT_EN undefined: combinational outputs, with reset gating as above.

## Test plan
All scenarios run in the combinational build; EX and MEM lanes are zero unless listed.
- ID = addi x1,x1,1 / addi x2,x2,2 / addi x3,x3,3 -> rollback 0; forwarding RS_REG; outputs equal inputs.
- Intra-bundle hazards:
  - ID = addi x1,x1,1 / addi x2,x1,1 / addi x3,x3,3 -> rollback 2; lanes 1-2 are bubbles.
  - Lane 2 = addi x2,x1,1 (lane 0 writes x1) -> rollback 1.
  - Lane 1 = add x3,x4,x1 (rs2 hazard) -> rollback 2.
- Load-use hazards, ID = addi x1,x1,1 / addi x2,x2,2 / addi x3,x3,3:
  - EX0 = lw x1,0(x1) -> rollback 3.
  - EX1 = lw x2 -> rollback 2.
  - EX2 = lw x3 with EX0 = addi x2 -> rollback 1.
  - EX1 = lw x1, EX2 = addi x1 -> rollback 0; forwarding_A[0] = RS_EX_2.
- ID = add x3,x1,x2 / addi x2,x2,2 / addi x1,x1,1, EX0 = addi x1, EX1 = addi x2 -> forwarding_A = {RS_EX_0, RS_EX_1, RS_EX_0}; forwarding_B[0] = RS_EX_1; rollback 0.
- Same ID bundle, EX1 = addi x2, MEM0 = addi x1 -> forwarding_A[0] = RS_MEM_0, forwarding_B[0] = RS_EX_1, forwarding_A[2] = RS_MEM_0.
- Reset high with a hazardous bundle -> rollback 0, all selects RS_REG, all outputs bubbles. With DETECTION_REG_OUT_EN, non-reset results appear one cycle later.
